// File: rtl/match_counter_pkg.sv
// Shared types and helpers for the match_counter window statistics block.
package match_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } out_state_e;

  // Increment val by inc, clamping at max_val; callers narrow the result to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/match_counter_if.sv
// Recognizer input plus the dav_/rfd four-phase delivery port of match_counter.
interface match_counter_if #(
  parameter int W = 8
);
  logic         z;
  logic         rfd;
  logic         dav_;
  logic [W-1:0] count;
  logic         lost;

  modport master (input z, input rfd, output dav_, output count, output lost);
  modport slave  (output z, output rfd, input dav_, input count, input lost);
endinterface

// File: rtl/window_timer.sv
// Free-running window timer; last flags the final clock of every WINDOW-clock window.
module window_timer #(
  parameter int WINDOW = 64
) (
  input  logic clock,
  input  logic reset,
  output logic last
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST_VAL = CW'(WINDOW - 1);

  if (WINDOW < 2) begin : g_bad_window
    $error("window_timer: WINDOW must be at least 2");
  end

  logic [CW-1:0] wcnt_q;
  logic [CW-1:0] wcnt_d;

  always_comb begin
    last   = (wcnt_q == LAST_VAL);
    wcnt_d = last ? '0 : wcnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/match_counter.sv
// Counts recognizer hits per window and delivers each window total over a dav_/rfd handshake,
// with a one-entry pending buffer and a sticky lost flag for overwritten totals.
module match_counter
  import match_counter_pkg::*;
#(
  parameter int W      = 8,
  parameter int WINDOW = 64
) (
  input  logic              clock,
  input  logic              reset,
  match_counter_if.master   bus
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic         last;
  logic [W-1:0] total;
  logic         consume;

  logic [W-1:0] acc_q, acc_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic         lost_q, lost_d;
  logic [W-1:0] count_q, count_d;
  out_state_e   state_q, state_d;

  window_timer #(
    .WINDOW (WINDOW)
  ) u_window_timer (
    .clock (clock),
    .reset (reset),
    .last  (last)
  );

  always_comb begin
    acc_d      = acc_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    lost_d     = lost_q;
    count_d    = count_q;
    state_d    = state_q;

    total   = W'(sat_inc(32'(acc_q), bus.z, 32'(MAX_VAL)));
    consume = (state_q == IDLE) && pend_q && bus.rfd;

    acc_d = last ? '0 : total;

    if (consume) begin
      pend_d = 1'b0;
    end

    // A window closing in the same clock the buffer drains is not an overwrite.
    if (last) begin
      pend_val_d = total;
      pend_d     = 1'b1;
      if (pend_q && !consume) begin
        lost_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (consume) begin
          count_d = pend_val_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!bus.rfd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      lost_q     <= 1'b0;
      count_q    <= '0;
      state_q    <= IDLE;
    end else begin
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      lost_q     <= lost_d;
      count_q    <= count_d;
      state_q    <= state_d;
    end
  end

  // dav_ is low exactly while a transfer is held, straight from the state flop.
  assign bus.dav_  = (state_q == IDLE);
  assign bus.count = count_q;
  assign bus.lost  = lost_q;

endmodule
